minmax_stream_driver: RTL and testbench
=======================================

// Module: minmax_stream_driver
// PURPOSE
//  Transmit side of the min/max-average byte-stream interface: holds an 8-byte frame written by a host,
//  replays it to the averaging core (start + one byte per clock), waits for done, captures W and
//  compares it against its own expected (min+max)/2. Sits between host/self-test logic and the averaging core.
// PARAMETERS
//  N_BYTES      8    bytes per frame (>=2)
//  DATA_W       8    byte width
//  TIMEOUT_CYC  32   clocks allowed in WAIT_DONE before timeout
// PORTS
//  clock        in   1        rising-edge clock
//  reset        in   1        synchronous, active-high
//  wr_en        in   1        host write strobe into frame buffer
//  wr_addr      in   3        buffer index 0..N_BYTES-1 ($clog2(N_BYTES))
//  wr_data      in   DATA_W   byte to store
//  go           in   1        launch frame transmission (single-cycle pulse)
//  start        out  1        to core: high exactly one cycle, with byte 0 on data
//  data         out  DATA_W   to core: current byte
//  W            in   DATA_W   from core: average result
//  done         in   1        from core: W valid this cycle
//  busy         out  1        high in SEND/WAIT_DONE
//  result       out  DATA_W   captured W
//  result_valid out  1        one-cycle pulse when result/match/timeout updated
//  match        out  1        result == expected (held until next result_valid)
//  timeout      out  1        last frame ended by timeout (held)
//  early_done   out  1        done seen during SEND (sticky until next go)
// BEHAVIOUR
//  - Reset: state IDLE; start=0, data=0, busy=0, result=0, result_valid=0, match=0, timeout=0,
//    early_done=0; frame buffer cleared to 0; counters 0. Reset mid-frame aborts with no result_valid.
//  - IDLE: wr_en writes buffer[wr_addr]; go -> SEND, clears early_done, idx=0.
//  - SEND (N_BYTES cycles): data=buffer[idx]; start=1 only when idx==0; idx++ each clock;
//    running min/max updated from buffer[idx] (idx 0 initialises both). After idx==N_BYTES-1 -> WAIT_DONE,
//    start=0, data=0. done in SEND sets early_done, otherwise ignored.
//  - WAIT_DONE: cycle counter from 0. done=1 -> capture result=W, match=(W==expected), timeout=0,
//    result_valid pulse next cycle, -> IDLE. Counter reaching TIMEOUT_CYC-1 without done ->
//    result unchanged, match=0, timeout=1, result_valid pulse, -> IDLE. done on the timeout cycle wins.
//  - expected = (min+max) >> 1 on a DATA_W+1-bit sum, truncated (no rounding, no overflow).
//  - go while busy ignored; wr_en while busy ignored (buffer frozen during frame).
//  - Latency: go at cycle 0 -> start at cycle 1 -> last byte at cycle N_BYTES -> WAIT_DONE from N_BYTES+1.
//  - Back-to-back: go in cycle result_valid is high is accepted.
// STRUCTURE
//  - Shared package: state enum (IDLE, SEND, WAIT_DONE), N_BYTES/DATA_W defaults, expected-average function.
//  - One natural sub-module: minmax_tracker (running min/max, init strobe, avg output), reusable by the core.
//  - Top: frame buffer regfile, FSM, idx counter, timeout counter, result registers.
// TESTING
//  - Reset behaviour: reset held 2 cycles, then all outputs 0, busy=0; reset mid-SEND -> IDLE, no result_valid.
//  - Frame {10,200,55,7,99,128,3,250}, model core returns W=126 -> start 1 cycle with data=10,
//    bytes in order, result=126, match=1.
//  - Same frame, model returns W=125 -> result=125, match=0, timeout=0.
//  - Extremes {0,255,...} -> expected 127; all bytes 8'hFF -> expected 255 (no overflow).
//  - Model never asserts done -> timeout=1, match=0 at exactly TIMEOUT_CYC cycles after WAIT_DONE entry.
//  - go/wr_en during busy ignored; done pulsed in SEND -> early_done=1; go in result_valid cycle relaunches.

Source files
------------

// File: rtl/minmax_stream_driver_pkg.sv
// rtl/minmax_stream_driver_pkg.sv - shared defaults, FSM encodings and average helper
package minmax_stream_driver_pkg;

    localparam int DEF_N_BYTES     = 8;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 32;

    // Helper width; any DATA_W up to this fits without overflow in the sum.
    localparam int AVG_MAX_W = 32;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    // Truncating midpoint: the sum carries one extra bit so (max+max)/2 never wraps.
    function automatic logic [AVG_MAX_W-1:0] mid_average(
        input logic [AVG_MAX_W-1:0] a,
        input logic [AVG_MAX_W-1:0] b
    );
        logic [AVG_MAX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[AVG_MAX_W:1];
    endfunction

endpackage

// File: rtl/minmax_tracker.sv
// rtl/minmax_tracker.sv - running min/max over a byte sequence with midpoint output
module minmax_tracker
    import minmax_stream_driver_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              update,
    input  logic              init,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg
);

    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] max_q;

    // The first sample of a sequence seeds both extremes; later ones only widen the range.
    always_ff @(posedge clock) begin
        if (reset) begin
            min_q <= '0;
            max_q <= '0;
        end else if (update) begin
            if (init) begin
                min_q <= sample;
                max_q <= sample;
            end else begin
                if (sample < min_q) min_q <= sample;
                if (sample > max_q) max_q <= sample;
            end
        end
    end

    // Midpoint of the current range, truncated.
    always_comb begin
        avg = DATA_W'(mid_average(AVG_MAX_W'(min_q), AVG_MAX_W'(max_q)));
    end

endmodule

// File: rtl/minmax_stream_driver.sv
// rtl/minmax_stream_driver.sv - replays a host-written frame to the averaging core and checks its answer
module minmax_stream_driver
    import minmax_stream_driver_pkg::*;
#(
    parameter int N_BYTES     = DEF_N_BYTES,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(N_BYTES)-1:0] wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       go,
    output logic                       start,
    output logic [DATA_W-1:0]          data,
    input  logic [DATA_W-1:0]          W,
    input  logic                       done,
    output logic                       busy,
    output logic [DATA_W-1:0]          result,
    output logic                       result_valid,
    output logic                       match,
    output logic                       timeout,
    output logic                       early_done
);

    localparam int              AW       = $clog2(N_BYTES);
    localparam int              TW       = $clog2(TIMEOUT_CYC);
    localparam logic [AW-1:0]   LAST_IDX = AW'(N_BYTES - 1);
    localparam logic [TW-1:0]   LAST_CYC = TW'(TIMEOUT_CYC - 1);

    logic [DATA_W-1:0] buffer [N_BYTES];
    logic [1:0]        state;
    logic [AW-1:0]     idx;
    logic [TW-1:0]     tcnt;
    logic [DATA_W-1:0] cur_byte;
    logic [DATA_W-1:0] expected;

    assign cur_byte = buffer[idx];

    // Frame buffer: host writes land only while idle so a frame in flight stays frozen.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_BYTES; i++) buffer[i] <= '0;
        end else if (wr_en && (state == ST_IDLE)) begin
            buffer[wr_addr] <= wr_data;
        end
    end

    // Range tracker follows the bytes exactly as they are presented to the core.
    minmax_tracker #(
        .DATA_W (DATA_W)
    ) u_tracker (
        .clock  (clock),
        .reset  (reset),
        .update (state == ST_SEND),
        .init   (idx == '0),
        .sample (cur_byte),
        .avg    (expected)
    );

    // Frame sequencer: launch, stream N_BYTES, then wait for done or give up.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            tcnt         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            match        <= 1'b0;
            timeout      <= 1'b0;
            early_done   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state      <= ST_SEND;
                        idx        <= '0;
                        early_done <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (done) early_done <= 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= ST_WAIT_DONE;
                        idx   <= '0;
                        tcnt  <= '0;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    // A done arriving on the last allowed cycle still counts as a result.
                    if (done) begin
                        result       <= W;
                        match        <= (W == expected);
                        timeout      <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= ST_IDLE;
                    end else if (tcnt == LAST_CYC) begin
                        match        <= 1'b0;
                        timeout      <= 1'b1;
                        result_valid <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Core-facing stream and status decode; data is forced to zero outside SEND.
    always_comb begin
        busy  = (state == ST_SEND) || (state == ST_WAIT_DONE);
        start = (state == ST_SEND) && (idx == '0);
        data  = (state == ST_SEND) ? cur_byte : '0;
    end

endmodule

// File: tb/tb_minmax_stream_driver.sv
// tb/tb_minmax_stream_driver.sv - directed self-checking bench for minmax_stream_driver
module tb_minmax_stream_driver;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       go;
    logic       start;
    logic [7:0] data;
    logic [7:0] W;
    logic       done;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       match;
    logic       timeout;
    logic       early_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] frame [8];

    minmax_stream_driver dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .go           (go),
        .start        (start),
        .data         (data),
        .W            (W),
        .done         (done),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .match        (match),
        .timeout      (timeout),
        .early_done   (early_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load_frame;
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = frame[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic run_frame(input string nm, input logic respond, input logic [7:0] w_val,
                             input logic [7:0] exp_res, input logic exp_match,
                             input logic inject, input logic b2b);
        int n;
        go = 1'b1;
        tick();
        go = 1'b0;
        check({nm, "/start0"}, start, 1);
        check({nm, "/data0"}, data, frame[0]);
        check({nm, "/busy0"}, busy, 1);
        check({nm, "/early_clr"}, early_done, 0);
        for (int i = 1; i < 8; i++) begin
            if (inject && i == 3) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'd77; go = 1'b1; done = 1'b1;
            end
            tick();
            wr_en = 1'b0; go = 1'b0; done = 1'b0;
            check({nm, "/start_lo"}, start, 0);
            check({nm, $sformatf("/data%0d", i)}, data, frame[i]);
        end
        tick();
        check({nm, "/wait_data"}, data, 0);
        check({nm, "/wait_start"}, start, 0);
        check({nm, "/wait_busy"}, busy, 1);
        if (inject) check({nm, "/early_done"}, early_done, 1);
        if (respond) begin
            W = w_val; done = 1'b1;
            tick();
            done = 1'b0;
            check({nm, "/rv"}, result_valid, 1);
            check({nm, "/result"}, result, exp_res);
            check({nm, "/match"}, match, exp_match);
            check({nm, "/timeout"}, timeout, 0);
            check({nm, "/busy_end"}, busy, 0);
        end else begin
            n = 0;
            while (!result_valid && n < 100) begin
                tick();
                n++;
            end
            check({nm, "/timeout_latency"}, n, 32);
            check({nm, "/timeout"}, timeout, 1);
            check({nm, "/match"}, match, 0);
            check({nm, "/result_kept"}, result, exp_res);
        end
        if (b2b) begin
            go = 1'b1;
            tick();
            go = 1'b0;
            check({nm, "/b2b_busy"}, busy, 1);
            check({nm, "/b2b_start"}, start, 1);
            check({nm, "/b2b_rv_drop"}, result_valid, 0);
        end else begin
            tick();
            check({nm, "/rv_pulse"}, result_valid, 0);
            check({nm, "/match_held"}, match, respond ? exp_match : 1'b0);
            check({nm, "/timeout_held"}, timeout, !respond);
        end
    endtask

    initial begin
        int seen;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0; W = '0; done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst/start", start, 0);
        check("rst/data", data, 0);
        check("rst/busy", busy, 0);
        check("rst/result", result, 0);
        check("rst/rv", result_valid, 0);
        check("rst/match", match, 0);
        check("rst/timeout", timeout, 0);
        check("rst/early", early_done, 0);

        // min 3, max 250 -> 126
        frame = '{8'd10, 8'd200, 8'd55, 8'd7, 8'd99, 8'd128, 8'd3, 8'd250};
        load_frame();
        run_frame("f1_match", 1'b1, 8'd126, 8'd126, 1'b1, 1'b0, 1'b0);
        run_frame("f1_miss", 1'b1, 8'd125, 8'd125, 1'b0, 1'b0, 1'b0);
        // go, wr_en and done injected mid-SEND
        run_frame("f1_inject", 1'b1, 8'd126, 8'd126, 1'b1, 1'b1, 1'b0);
        // buffer must still start with 10; core stays silent
        run_frame("f1_tmo", 1'b0, 8'd0, 8'd126, 1'b0, 1'b0, 1'b0);

        // min 0, max 255 -> 127
        frame = '{8'd0, 8'd255, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        load_frame();
        run_frame("ext", 1'b1, 8'd127, 8'd127, 1'b1, 1'b0, 1'b0);

        // all 0xFF -> 255, relaunched in the result_valid cycle
        frame = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        load_frame();
        run_frame("ff", 1'b1, 8'd255, 8'd255, 1'b1, 1'b0, 1'b1);

        // abort the relaunched frame with reset mid-SEND
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst/busy", busy, 0);
        check("midrst/start", start, 0);
        check("midrst/data", data, 0);
        check("midrst/rv", result_valid, 0);
        check("midrst/result", result, 0);
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (result_valid || busy) seen++;
        end
        check("midrst/quiet", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
